// File: rtl/sdram_line_client_if.sv
// Bundle of the CPU-side request port and the SDRAM line-controller port.
// slave is the view of sdram_line_client; master is the view of the CPU and SDRAM side.
`timescale 1ns/1ps
interface sdram_line_client_if;
    typedef struct packed {
        logic [15:0] w7, w6, w5, w4, w3, w2, w1, w0;
    } sdram_8_wd_t;

    logic [31:0] cpu_addr;
    logic        cpu_wr;
    logic        cpu_rd;
    logic        cpu_valid;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_done;

    logic [23:0] mem_addr;
    logic        mem_wr;
    logic        mem_rd;
    logic        mem_valid;
    sdram_8_wd_t mem_line_out;
    sdram_8_wd_t mem_line_in;
    logic        mem_done;
    logic        mem_init_done;

    modport master (
        output cpu_addr, cpu_wr, cpu_rd, cpu_valid, cpu_wdata, cpu_be,
        input  cpu_rdata, cpu_done,
        input  mem_addr, mem_wr, mem_rd, mem_valid, mem_line_out,
        output mem_line_in, mem_done, mem_init_done
    );

    modport slave (
        input  cpu_addr, cpu_wr, cpu_rd, cpu_valid, cpu_wdata, cpu_be,
        output cpu_rdata, cpu_done,
        output mem_addr, mem_wr, mem_rd, mem_valid, mem_line_out,
        input  mem_line_in, mem_done, mem_init_done
    );
endinterface

// File: rtl/sdram_line_client.sv
// Single-line, write-through, read-modify-write buffer between the CPU data port
// and the SDRAM line controller.
`timescale 1ns/1ps
module sdram_line_client (
    input  logic                clk,
    input  logic                rst,
    sdram_line_client_if.slave  bus
);
    localparam int DATA_W = 32;
    localparam int LINE_W = 128;
    localparam int TAG_W  = 21;

    typedef enum logic [2:0] {IDLE, FILL, MERGE, WB, RESP} state_t;

    state_t              state, state_nxt;
    logic [LINE_W-1:0]   line, line_nxt;
    logic [TAG_W-1:0]    line_tag, tag_nxt;
    logic                line_vld, vld_nxt;
    logic                mem_valid_r, mem_valid_nxt;
    logic                mem_wr_r, mem_wr_nxt;
    logic                mem_rd_r, mem_rd_nxt;
    logic [23:0]         mem_addr_r, mem_addr_nxt;
    logic [LINE_W-1:0]   mem_line_r, mem_line_nxt;

    logic [TAG_W-1:0]    cpu_tag;
    logic [1:0]          word_k;
    logic                req, hit;
    logic [LINE_W-1:0]   merged;
    logic [23:0]         line_addr;
    logic                unused_addr_bits;

    // Word k occupies bits [32k+31:32k]; byte b of the word is bits [32k+8b+7:32k+8b].
    function automatic logic [LINE_W-1:0] merge_bytes(input logic [LINE_W-1:0] l,
                                                      input logic [1:0] k,
                                                      input logic [DATA_W-1:0] wdata,
                                                      input logic [3:0] be);
        logic [LINE_W-1:0] r;
        r = l;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[int'(k) * 32 + b * 8 +: 8] = wdata[b * 8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] sel_word(input logic [LINE_W-1:0] l,
                                                   input logic [1:0] k);
        return l[int'(k) * 32 +: 32];
    endfunction

    assign cpu_tag          = bus.cpu_addr[24:4];
    assign word_k           = bus.cpu_addr[3:2];
    assign line_addr        = {cpu_tag, 3'b000};
    assign req              = bus.cpu_valid && (bus.cpu_wr || bus.cpu_rd) && bus.mem_init_done;
    assign hit              = line_vld && (line_tag == cpu_tag);
    assign merged           = merge_bytes(line, word_k, bus.cpu_wdata, bus.cpu_be);
    assign unused_addr_bits = ^{bus.cpu_addr[31:25], bus.cpu_addr[1:0]};

    always_comb begin
        state_nxt     = state;
        line_nxt      = line;
        tag_nxt       = line_tag;
        vld_nxt       = line_vld;
        mem_valid_nxt = mem_valid_r;
        mem_wr_nxt    = mem_wr_r;
        mem_rd_nxt    = mem_rd_r;
        mem_addr_nxt  = mem_addr_r;
        mem_line_nxt  = mem_line_r;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit && bus.cpu_wr) begin
                        line_nxt      = merged;
                        mem_valid_nxt = 1'b1;
                        mem_wr_nxt    = 1'b1;
                        mem_rd_nxt    = 1'b0;
                        mem_addr_nxt  = line_addr;
                        mem_line_nxt  = merged;
                        state_nxt     = WB;
                    end else if (hit) begin
                        state_nxt     = RESP;
                    end else begin
                        mem_valid_nxt = 1'b1;
                        mem_wr_nxt    = 1'b0;
                        mem_rd_nxt    = 1'b1;
                        mem_addr_nxt  = line_addr;
                        state_nxt     = FILL;
                    end
                end
            end
            FILL: begin
                if (bus.mem_done) begin
                    line_nxt      = bus.mem_line_in;
                    tag_nxt       = cpu_tag;
                    vld_nxt       = 1'b1;
                    mem_valid_nxt = 1'b0;
                    mem_rd_nxt    = 1'b0;
                    state_nxt     = bus.cpu_wr ? MERGE : RESP;
                end
            end
            // mem_valid is low for this cycle, separating the fill from the write-back.
            MERGE: begin
                line_nxt      = merged;
                mem_valid_nxt = 1'b1;
                mem_wr_nxt    = 1'b1;
                mem_rd_nxt    = 1'b0;
                mem_addr_nxt  = line_addr;
                mem_line_nxt  = merged;
                state_nxt     = WB;
            end
            WB: begin
                if (bus.mem_done) begin
                    mem_valid_nxt = 1'b0;
                    mem_wr_nxt    = 1'b0;
                    state_nxt     = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            line        <= '0;
            line_tag    <= '0;
            line_vld    <= 1'b0;
            mem_valid_r <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_rd_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_line_r  <= '0;
        end else begin
            state       <= state_nxt;
            line        <= line_nxt;
            line_tag    <= tag_nxt;
            line_vld    <= vld_nxt;
            mem_valid_r <= mem_valid_nxt;
            mem_wr_r    <= mem_wr_nxt;
            mem_rd_r    <= mem_rd_nxt;
            mem_addr_r  <= mem_addr_nxt;
            mem_line_r  <= mem_line_nxt;
        end
    end

    assign bus.mem_valid    = mem_valid_r;
    assign bus.mem_wr       = mem_wr_r;
    assign bus.mem_rd       = mem_rd_r;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_line_out = mem_line_r;
    assign bus.cpu_done     = (state == RESP);
    assign bus.cpu_rdata    = (state == RESP) ? sel_word(line, word_k) : '0;
endmodule
